// File: rtl/rpn_evaluator.sv
// rpn_evaluator: RPN token evaluator with an operand stack and strobe/ack
// handshakes on the token and result sides.
// Optional error detection: define RPN_EVALUATOR_ERR_EN to enable the sticky
// error flag; without it out_err is tied low and errors degrade gracefully.
module rpn_evaluator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_stb,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_is_op,
  output logic             in_ack,
  output logic             out_stb,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             out_ack
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, RELEASE, RESULT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [SPW-1:0]   sp;
  logic [SPW-1:0]   sp_exec;
  logic [IW-1:0]    top_idx, res_idx;
  logic [WIDTH-1:0] opa, opb, alu;
  logic             op_arith, tok_push, full;
  logic [WIDTH-1:0] eq_data;
  logic             eq_err;

  assign tok_push = (state == IDLE) && in_stb && !in_is_op;
  assign full     = (sp == SPW'(DEPTH));
  assign op_arith = (op_q == OP_MUL) || (op_q == OP_ADD) || (op_q == OP_SUB);
  assign top_idx  = IW'(sp - SPW'(1));

  // Missing operands read as zero; the result lands where A was (or slot 0
  // when fewer than two operands exist), so depth nets -1 or stays at 1.
  assign opb     = (sp != '0)       ? stk[top_idx] : '0;
  assign opa     = (sp >= SPW'(2))  ? stk[IW'(sp - SPW'(2))] : '0;
  assign res_idx = (sp >= SPW'(2))  ? IW'(sp - SPW'(2)) : '0;
  assign sp_exec = (sp >= SPW'(2))  ? sp - SPW'(1) : SPW'(1);

  // ALU: all results are modulo 2^WIDTH
  always_comb begin
    alu = '0;
    case (op_q)
      OP_MUL:  alu = opa * opb;
      OP_ADD:  alu = opa + opb;
      OP_SUB:  alu = opa - opb;
      default: alu = '0;
    endcase
  end

`ifdef RPN_EVALUATOR_ERR_EN
  logic err_flag, err_set, tok_eq;
  assign tok_eq  = (state == IDLE) && in_stb && in_is_op && (in_data[2:0] == OP_EQ);
  assign err_set = (tok_push && full) ||
                   ((state == EXEC) && (!op_arith || (sp < SPW'(2)))) ||
                   (tok_eq && (sp != SPW'(1)));
  assign eq_err  = err_flag || (sp != SPW'(1));

  // Sticky error flag, cleared when the result is consumed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            err_flag <= 1'b0;
    else if (state == RESULT && out_ack) err_flag <= 1'b0;
    else if (err_set)                   err_flag <= 1'b1;
  end
`else
  assign eq_err = 1'b0;
`endif

  assign eq_data = (eq_err || (sp == '0)) ? '0 : stk[top_idx];

  // Stack storage: operand push or operator result write-back
  always_ff @(posedge CLK) begin
    if (tok_push && !full)          stk[IW'(sp)] <= in_data;
    else if (state == EXEC && op_arith) stk[res_idx] <= alu;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_stb) begin
        if (!in_is_op)                   state_nxt = RELEASE;
        else if (in_data[2:0] == OP_EQ)  state_nxt = RESULT;
        else                             state_nxt = EXEC;
      end
      EXEC:    state_nxt = RELEASE;
      RESULT:  if (out_ack) state_nxt = RELEASE;
      RELEASE: if (!in_stb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: stack pointer, opcode capture, ack pulse and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp       <= '0;
      op_q     <= '0;
      in_ack   <= 1'b0;
      out_stb  <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      in_ack <= 1'b0;
      case (state)
        IDLE: if (in_stb) begin
          if (!in_is_op) begin
            if (!full) sp <= sp + SPW'(1);
            in_ack <= 1'b1;
          end else if (in_data[2:0] == OP_EQ) begin
            out_stb  <= 1'b1;
            out_data <= eq_data;
            out_err  <= eq_err;
          end else begin
            op_q <= in_data[2:0];
          end
        end
        EXEC: begin
          if (op_arith) sp <= sp_exec;
          in_ack <= 1'b1;
        end
        RESULT: if (out_ack) begin
          out_stb  <= 1'b0;
          out_data <= '0;
          out_err  <= 1'b0;
          sp       <= '0;
          in_ack   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_evaluator.sv
// Bench for rpn_evaluator: queue-based reference model, per-cycle output
// compare, directed token sequences with literal expectations.
module tb_rpn_evaluator;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
`ifdef RPN_EVALUATOR_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic             CLK = 1'b0, RST = 1'b1;
  logic             in_stb = 1'b0, in_is_op = 1'b0, out_ack = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ack, out_stb, out_err;
  logic [WIDTH-1:0] out_data;

  rpn_evaluator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .in_stb(in_stb), .in_data(in_data), .in_is_op(in_is_op),
    .in_ack(in_ack), .out_stb(out_stb), .out_data(out_data), .out_err(out_err),
    .out_ack(out_ack)
  );

  always #5 CLK = ~CLK;

  int checks = 0, passes = 0, ack_cnt = 0;
  logic [31:0] mstk[$];
  bit          merr = 0, pending = 0;
  logic [31:0] exp_data = '0;
  logic        exp_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model operations
  task automatic m_push(input logic [31:0] v);
    if (mstk.size() == DEPTH) merr = merr | ERR;
    else mstk.push_back(v);
  endtask

  task automatic m_op(input logic [2:0] code);
    logic [31:0] a, b;
    int n;
    if (code >= 3'd1 && code <= 3'd3) begin
      n = mstk.size();
      b = (n >= 1) ? mstk.pop_back() : 32'd0;
      a = (n >= 2) ? mstk.pop_back() : 32'd0;
      if (n < 2) merr = merr | ERR;
      case (code)
        3'd1: mstk.push_back(a * b);
        3'd2: mstk.push_back(a + b);
        default: mstk.push_back(a - b);
      endcase
    end else merr = merr | ERR;
  endtask

  task automatic m_eq();
    if (mstk.size() != 1) merr = merr | ERR;
    exp_err  = merr;
    exp_data = merr ? 32'd0 : (mstk.size() > 0 ? mstk[$] : 32'd0);
  endtask

  task automatic m_clear();
    mstk.delete();
    merr = 0;
  endtask

  // Count in_ack high cycles
  always @(negedge CLK) if (in_ack) ack_cnt++;

  // Per-cycle compare of the result port against the model
  always @(negedge CLK) begin
    if (!RST) begin
      if (out_stb) begin
        chk("out_stb_unexpected", {31'd0, pending}, 32'd1);
        chk("out_data", out_data, exp_data);
        chk("out_err", {31'd0, out_err}, {31'd0, exp_err});
      end else begin
        chk("idle_out_data", out_data, 32'd0);
        chk("idle_out_err", {31'd0, out_err}, 32'd0);
      end
    end
  end

  task automatic send(input logic [31:0] v, input bit is_op, input int hold);
    int a0, n;
    bit got;
    if (is_op) m_op(v[2:0]); else m_push(v);
    a0 = ack_cnt; got = 0; n = 0;
    @(negedge CLK);
    in_stb = 1'b1; in_is_op = is_op; in_data = v;
    for (int i = 1; i <= 10; i++) begin
      @(posedge CLK); #1;
      if (in_ack) begin got = 1; n = i; break; end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("ack_latency", n, is_op ? 32'd2 : 32'd1);
    repeat (hold) @(posedge CLK);
    @(negedge CLK);
    in_stb = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("ack_once", ack_cnt - a0, 32'd1);
  endtask

  task automatic wait_out(output bit got);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (out_stb) begin got = 1; break; end
    end
  endtask

  task automatic do_eq(input int delay, input logic [31:0] lit_d, input logic lit_e);
    int a0;
    bit got;
    logic [31:0] d0;
    m_eq();
    pending = 1;
    a0 = ack_cnt;
    @(negedge CLK);
    in_stb = 1'b1; in_is_op = 1'b1; in_data = 32'd4;
    wait_out(got);
    chk("result_seen", {31'd0, got}, 32'd1);
    chk("no_ack_in_result", {31'd0, in_ack}, 32'd0);
    chk("lit_data", out_data, lit_d);
    chk("lit_err", {31'd0, out_err}, {31'd0, lit_e});
    d0 = out_data;
    for (int i = 0; i < delay; i++) begin
      @(posedge CLK); #1;
      chk("hold_stb", {31'd0, out_stb}, 32'd1);
      chk("hold_data", out_data, d0);
      chk("hold_no_ack", {31'd0, in_ack}, 32'd0);
    end
    @(negedge CLK);
    out_ack = 1'b1;
    @(posedge CLK); #1;
    chk("eq_ack", {31'd0, in_ack}, 32'd1);
    chk("stb_drop", {31'd0, out_stb}, 32'd0);
    pending = 0;
    m_clear();
    @(negedge CLK);
    out_ack = 1'b0; in_stb = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("eq_ack_once", ack_cnt - a0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    repeat (2) @(negedge CLK);
    chk("rst_in_ack", {31'd0, in_ack}, 32'd0);
    chk("rst_out_stb", {31'd0, out_stb}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    RST = 1'b0;

    // 3 4 + 2 * = -> 14
    send(3, 0, 0); send(4, 0, 0); send(2, 1, 0); send(2, 0, 0); send(1, 1, 0);
    do_eq(0, 32'd14, 1'b0);
    // 5 9 - = -> wraps
    send(5, 0, 0); send(9, 0, 0); send(3, 1, 0);
    do_eq(0, 32'hFFFF_FFFC, 1'b0);
    // product truncation
    send(32'h10000, 0, 0); send(32'h10000, 0, 0); send(1, 1, 0);
    do_eq(0, 32'd0, 1'b0);
    // underflow
    send(2, 1, 0);
    do_eq(0, 32'd0, ERR);
    // long strobes and delayed out_ack
    send(6, 0, 3); send(7, 0, 3); send(2, 1, 3);
    do_eq(5, 32'd13, 1'b0);
    // invalid opcode
    send(3, 0, 0); send(7, 1, 0);
    do_eq(0, ERR ? 32'd0 : 32'd3, ERR);
    // overflow: 17th push dropped
    for (int i = 1; i <= 17; i++) send(i, 0, 0);
    do_eq(0, ERR ? 32'd0 : 32'd16, ERR);
    // full stack then operator
    for (int i = 1; i <= 16; i++) send(i, 0, 0);
    send(2, 1, 0);
    do_eq(0, ERR ? 32'd0 : 32'd31, ERR);
    // empty '='
    do_eq(0, 32'd0, ERR);

    // reset mid-RESULT
    send(1, 0, 0); send(2, 0, 0);
    m_eq(); pending = 1;
    @(negedge CLK);
    in_stb = 1'b1; in_is_op = 1'b1; in_data = 32'd4;
    wait_out(got);
    chk("pre_rst_result", {31'd0, got}, 32'd1);
    @(negedge CLK); #2;
    RST = 1'b1; in_stb = 1'b0; in_is_op = 1'b0;
    #1;
    chk("rst_mid_stb", {31'd0, out_stb}, 32'd0);
    chk("rst_mid_data", out_data, 32'd0);
    chk("rst_mid_ack", {31'd0, in_ack}, 32'd0);
    pending = 0; m_clear();
    @(negedge CLK);
    RST = 1'b0;
    send(7, 0, 0);
    do_eq(0, 32'd7, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/rpn_evaluator.md
RPN_EVALUATOR -- requirements
Module: rpn_evaluator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the operand stack capacity in entries.
REQ-003 Port CLK  input  1  clock; all state SHALL change on its rising edge.
REQ-004 Port RST  input  1  reset, asynchronous, active-high.
REQ-005 Port in_stb  input  1  token valid; held high by the producer until in_ack is seen.
REQ-006 Port in_data  input  WIDTH  token: an operand value, or an opcode in bits [2:0].
REQ-007 Port in_is_op  input  1  1 = in_data is an operator token, 0 = operand token.
REQ-008 Port in_ack  output  1  one-cycle pulse meaning the token is consumed.
REQ-009 Port out_stb  output  1  result valid; held high until out_ack is seen.
REQ-010 Port out_data  output  WIDTH  evaluated result.
REQ-011 Port out_err  output  1  result invalid; qualified by out_stb.
REQ-012 Port out_ack  input  1  the consumer has taken the result.

Function
REQ-013 Opcodes SHALL be: 001 '*', 010 '+', 011 '-', 100 '='; every other code is invalid.
REQ-014 The FSM SHALL have states IDLE, EXEC, RELEASE and RESULT.
REQ-015 Operand token: in IDLE with in_stb=1 and in_is_op=0, the value SHALL be pushed and in_ack SHALL be high on the next cycle; the FSM then goes to RELEASE.
REQ-016 Arithmetic operator token: IDLE -> EXEC (one cycle). EXEC SHALL pop B (top) and A (next), push A op B, pulse in_ack, then go to RELEASE. Operator latency is 2 cycles from sample to in_ack.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH: '-' is A-B, '*' keeps the low WIDTH bits of the product, and '+' discards the carry.
REQ-018 RELEASE SHALL hold in_ack low and return to IDLE only after in_stb is sampled low, so one strobe is never consumed twice.
REQ-019 '=' token: IDLE -> RESULT, with out_data = top of stack, out_stb=1, and out_err = the sticky error flag; in_ack SHALL NOT be asserted yet.
REQ-020 In RESULT, out_stb, out_data and out_err SHALL remain stable until out_ack=1.
REQ-021 On out_ack in RESULT, the block SHALL drop out_stb, empty the stack, clear the error flag, pulse in_ack, and go to RELEASE.
REQ-022 in_stb SHALL be ignored in EXEC and RESULT; out_ack SHALL be ignored outside RESULT.
REQ-023 When out_stb=0, out_data and out_err SHALL be driven 0.
REQ-024 A full stack with an operator token SHALL still be legal, because an operator nets one pop.

Reset
REQ-025 RST SHALL force the FSM to IDLE, empty the stack, clear the error flag, and drive in_ack=0, out_stb=0, out_data=0 and out_err=0, at any time including mid-RESULT.
REQ-026 The first token after RST deassertion SHALL be accepted with the normal latency.

Configuration
REQ-027 The macro RPN_EVALUATOR_ERR_EN SHALL select error detection.
REQ-028 With RPN_EVALUATOR_ERR_EN defined, the sticky error flag SHALL be set by:
  - an operator with depth<2;
  - an operand push with depth=DEPTH, where the push is dropped;
  - an invalid opcode;
  - '=' with depth!=1.
  The offending token SHALL still be acked, and the result out_data SHALL be 0 whenever the flag is set.
REQ-029 Without RPN_EVALUATOR_ERR_EN, out_err SHALL be tied 0 and these rules SHALL apply:
  - missing operands read as 0;
  - an overflow push is dropped;
  - an invalid opcode is acked as a no-op;
  - '=' outputs the top of stack, or 0 if the stack is empty.

Verification
REQ-030 Tokens 3, 4, '+', 2, '*', '=' -> out_data=14, out_err=0; stack empty after out_ack.
REQ-031 Tokens 5, 9, '-', '=' -> out_data=0xFFFFFFFC.
REQ-032 Tokens 0x10000, 0x10000, '*', '=' -> out_data=0x00000000.
REQ-033 Tokens '+', '=' with ERR_EN defined -> out_err=1, out_data=0; without ERR_EN -> out_err=0, out_data=0.
REQ-034 out_ack delayed 5 cycles after out_stb -> out_stb/out_data stable all 5 cycles, and in_ack pulses exactly once per token; in_stb held 3 cycles past in_ack -> no double push.
REQ-035 RST pulsed while in RESULT -> out_stb=0 next edge; then tokens 7, '=' -> out_data=7.
